// File: rtl/digit_serial_subtractor.sv
// Digit-serial ripple-borrow subtractor: diff = a - b - bin, DIGIT bits per clock, LSB digit first.
// Optional signed-overflow flag enabled by defining SUBTRACTOR_OVF_EN; otherwise ovf_o is tied to 0.
module digit_serial_subtractor #(
  parameter int BITS  = 8,
  parameter int DIGIT = 2
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [BITS-1:0] a_i,
  input  logic [BITS-1:0] b_i,
  input  logic            bin_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [BITS-1:0] diff_o,
  output logic            bout_o,
  output logic            ovf_o,
  output logic [1:0]      state_o
);

  localparam int N     = BITS / DIGIT;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [BITS-1:0]  a_q, b_q, diff_q, diff_d;
  logic             borrow_q, bout_q;
  logic [CNT_W-1:0] cnt_q;
  logic [DIGIT-1:0] a_sl, b_sl;
  logic [DIGIT:0]   slice_res;
  logic             accept, run_last;

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
  // valid never waits on ready, and the offered data is held until that edge.
  assign accept   = in_valid_i & in_ready_o;
  assign run_last = (state_q == RUN) && (cnt_q == LAST_CNT);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid_i) state_d = RUN;
      RUN:     if (cnt_q == LAST_CNT) state_d = DONE;
      DONE:    if (out_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready_o  = (state_q == IDLE) && !rst_i;
    out_valid_o = (state_q == DONE);
    state_o     = state_q;
  end

  // One digit of ripple-borrow: widen by one bit so the borrow lands in the MSB.
  always_comb begin
    a_sl      = a_q[int'(cnt_q) * DIGIT +: DIGIT];
    b_sl      = b_q[int'(cnt_q) * DIGIT +: DIGIT];
    slice_res = {1'b0, a_sl} - {1'b0, b_sl} - {{DIGIT{1'b0}}, borrow_q};
    diff_d    = diff_q;
    diff_d[int'(cnt_q) * DIGIT +: DIGIT] = slice_res[DIGIT-1:0];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      a_q      <= '0;
      b_q      <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      bout_q   <= 1'b0;
      cnt_q    <= '0;
    end else if (accept) begin
      a_q      <= a_i;
      b_q      <= b_i;
      diff_q   <= '0;
      borrow_q <= bin_i;
      bout_q   <= 1'b0;
      cnt_q    <= '0;
    end else if (state_q == RUN) begin
      diff_q   <= diff_d;
      borrow_q <= slice_res[DIGIT];
      cnt_q    <= run_last ? '0 : cnt_q + CNT_W'(1);
      if (run_last) bout_q <= slice_res[DIGIT];
    end
  end

  assign diff_o = diff_q;
  assign bout_o = bout_q;

`ifdef SUBTRACTOR_OVF_EN
  logic ovf_q, ovf_d;

  // Overflow only possible when operand signs differ; the final MSB is taken from diff_d.
  assign ovf_d = (a_q[BITS-1] != b_q[BITS-1]) && (diff_d[BITS-1] != a_q[BITS-1]);

  always_ff @(posedge clk_i) begin
    if (rst_i || accept) begin
      ovf_q <= 1'b0;
    end else if (run_last) begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf_o = ovf_q;
`else
  assign ovf_o = 1'b0;
`endif

endmodule

// File: doc/digit_serial_subtractor.md
# digit_serial_subtractor

- Multi-cycle ripple-borrow subtractor: computes a − b − bin, DIGIT bits per clock, least-significant digit first, with a single borrow register carried between digits.
- Sequential counterpart to the combinational ripple-carry adder in the arithmetic library; trades latency for area when a full-width borrow chain is too long for the target clock.
- Operands and results move over valid/ready handshakes, so it sits directly between producer and consumer stages of the datapath.

## Interface
- BITS, default 8: operand/result width; must be an integer multiple of DIGIT.
- DIGIT, default 2: bits processed per cycle; N = BITS/DIGIT cycles per operation.
- clk  input  1  clock, all logic on rising edge.
- rst  input  1  reset, synchronous, active-high.
- in_valid  input  1  operand set offered.
- in_ready  output  1  block can accept operands.
- a  input  BITS  minuend (unsigned or two's complement).
- b  input  BITS  subtrahend.
- bin  input  1  borrow-in.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts result.
- diff  output  BITS  (a − b − bin) mod 2^BITS.
- bout  output  1  borrow-out; 1 iff a < b + bin (unsigned).
- ovf  output  1  signed overflow flag (see Configuration).

## Operation
- FSM states IDLE, RUN, DONE; reset state IDLE.
- IDLE: in_ready=1. On in_valid&in_ready: latch a, b; borrow reg ← bin; digit counter ← 0; clear result reg; → RUN.
- RUN: each cycle, slice k = counter: {borrow', diff[k]} = a[k] − b[k] − borrow (DIGIT-bit ripple-borrow); write slice, update borrow, counter+1. After slice N−1 → DONE; counter resets to 0.
- DONE: out_valid=1; diff, bout (= final borrow), ovf held stable. On out_valid&out_ready → IDLE.
- in_ready=0 in RUN and DONE; inputs ignored there. a, b changes after acceptance do not affect the result.
- Width rules: internal slice arithmetic is DIGIT+1 bits; borrow is bit DIGIT of the slice result, inverted-carry convention not used.
- DIGIT = BITS legal: N=1, RUN lasts one cycle.

## Timing
- Reset values: out_valid=0, diff=0, bout=0, ovf=0; in_ready=0 while rst high, 1 the cycle after release.
- Accept at edge T → RUN during cycles T..T+N−1 → out_valid=1 from edge T+N.
- Result held indefinitely under out_ready=0; out_valid drops the cycle after the accepting edge; in_ready=1 the same cycle.
- Throughput: one operation per N+2 cycles with no backpressure; no overlap of accept and result.
- out_ready high before out_valid has no effect.
- rst mid-RUN or mid-DONE: operation discarded, no out_valid, all outputs to reset values on next edge.

## Configuration
- SUBTRACTOR_OVF_EN defined: ovf = (a[BITS−1] ≠ b[BITS−1]) & (diff[BITS−1] ≠ a[BITS−1]), computed on the latched operands, registered into DONE with diff; bin included in diff.
- Undefined: ovf tied to 0, no overflow logic synthesized; port still present.

## Test plan
- BITS=8, DIGIT=2: a=0x5A, b=0x3C, bin=0 accepted at T → out_valid at T+4, diff=0x1E, bout=0, ovf=0.
- a=0x00, b=0x01, bin=0 → diff=0xFF, bout=1, ovf=0; a=0x10, b=0x0F, bin=1 → diff=0x00, bout=0.
- SUBTRACTOR_OVF_EN: a=0x80, b=0x01 → diff=0x7F, bout=0, ovf=1; a=0x7F, b=0x80 → diff=0xFF, bout=1, ovf=1; without macro ovf=0 for both.
- Backpressure: hold out_ready=0 five cycles after out_valid → diff/bout stable, in_ready=0, new in_valid ignored; raise out_ready → out_valid=0 and in_ready=1 next cycle.
- Assert rst two cycles into RUN → no out_valid, outputs 0, next operation 0x5A−0x3C returns 0x1E correctly.
- Back-to-back 100 random operand sets with random out_ready → every result matches (a−b−bin) mod 256 and borrow reference; DIGIT=1 and DIGIT=8 also run.
